// File: rtl/sys_desc_pkg.sv
// sys_desc_pkg: shared state encoding, default geometry and data widths for the descriptor reader.
package sys_desc_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int ROM_LATENCY_DEF = 2;
  localparam int ROM_AW_DEF = 9;
  localparam int DATA_W = 32;
  localparam int ROM_DW = 64;
endpackage

// File: rtl/sys_desc_rd_cache.sv
// sys_desc_rd_cache: one-entry 64-bit read cache tagged by ROM word address; flush beats a same-cycle fill.
import sys_desc_pkg::*;
module sys_desc_rd_cache #(
  parameter int AW = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [AW-1:0]     fill_tag,
  input  logic [ROM_DW-1:0] fill_data,
  input  logic              flush,
  input  logic [AW-1:0]     tag,
  output logic              hit,
  output logic [ROM_DW-1:0] data
);
  logic          valid;
  logic [AW-1:0] tag_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag_q <= '0;
      data  <= '0;
    end else begin
      valid <= flush ? 1'b0 : (fill ? 1'b1 : valid);
      if (fill) begin
        tag_q <= fill_tag;
        data  <= fill_data;
      end
    end
  end
  assign hit = valid && (tag_q == tag);
endmodule

// File: rtl/sys_desc_reader.sv
// sys_desc_reader: 32-bit host reads of a 64-bit ROM with fixed latency.
// SYS_DESC_RDCACHE_EN adds a one-entry read cache; without it flush is ignored.
import sys_desc_pkg::*;
module sys_desc_reader #(
  parameter int ROM_LATENCY = ROM_LATENCY_DEF,
  parameter int ROM_AW = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW:0]   s_address,
  input  logic              s_read,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  input  logic              flush,
  output logic [ROM_AW-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [ROM_DW-1:0] rom_readdata
);
  state_t            state, state_n;
  logic [2:0]        cnt;
  logic              half;
  logic [ROM_DW-1:0] word;
  logic              accept, fill, hit;
  logic [ROM_DW-1:0] hit_data;
  assign accept = s_read && !s_waitrequest;
  assign fill = (state == WAIT) && (cnt == 3'd0);
`ifdef SYS_DESC_RDCACHE_EN
  sys_desc_rd_cache #(.AW(ROM_AW)) u_cache (
    .clk(clk),
    .reset(reset),
    .fill(fill),
    .fill_tag(rom_address),
    .fill_data(rom_readdata),
    .flush(flush),
    .tag(s_address[ROM_AW:1]),
    .hit(hit),
    .data(hit_data)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  always_comb begin
    state_n = (state == IDLE)  ? (accept ? (hit ? RESP : ISSUE) : IDLE) :
              (state == ISSUE) ? WAIT :
              (state == WAIT)  ? (fill ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      s_waitrequest   <= 1'b1;
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
      rom_address     <= '0;
      rom_chipselect  <= 1'b0;
      rom_clken       <= 1'b0;
      cnt             <= '0;
      half            <= 1'b0;
      word            <= '0;
    end else begin
      state           <= state_n;
      rom_clken       <= 1'b1;
      s_waitrequest   <= state_n != IDLE;
      rom_chipselect  <= state_n == ISSUE;
      s_readdatavalid <= state == RESP;
      if (state == IDLE && accept) begin
        half <= s_address[0];
        if (hit) word <= hit_data;
        else rom_address <= s_address[ROM_AW:1];
      end
      if (state == ISSUE) cnt <= 3'(ROM_LATENCY - 1);
      else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (fill) word <= rom_readdata;
      if (state == RESP) s_readdata <= half ? word[63:32] : word[31:0];
    end
  end
endmodule

// File: tb/tb_sys_desc_reader.sv
// tb_sys_desc_reader: directed reads against a pipelined ROM model; cache expectations follow SYS_DESC_RDCACHE_EN.
module tb_sys_desc_reader;
  localparam int L = 2;
`ifdef SYS_DESC_RDCACHE_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_CS = 0;
`else
  localparam int HIT_LAT = 4;
  localparam int HIT_CS = 1;
`endif
  logic        clk = 0, reset = 1, s_read = 0, flush = 0;
  logic [9:0]  s_address = '0;
  logic        s_waitrequest, s_readdatavalid, rom_chipselect, rom_clken;
  logic [31:0] s_readdata;
  logic [8:0]  rom_address;
  logic [63:0] rom_readdata, p1, p2;
  logic [63:0] mem [512];
  int n_vec = 0, n_bad = 0;

  sys_desc_reader #(.ROM_LATENCY(L), .ROM_AW(9)) dut (
    .clk(clk), .reset(reset), .s_address(s_address), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .flush(flush),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect),
    .rom_clken(rom_clken), .rom_readdata(rom_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_clken) begin
    p1 <= mem[rom_address];
    p2 <= p1;
  end
  assign rom_readdata = p2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // starts and ends at a negedge; fl selects the response-cycle index at which flush pulses
  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] d,
                    input int lat, input int ncs, input int fl);
    int g, n, cs;
    s_address = a;
    s_read = 1;
    g = 0;
    while (s_waitrequest && g < 20) begin @(negedge clk); g++; end
    chk({tag, "_acc"}, 64'(s_waitrequest), 64'd0);
    @(posedge clk);
    @(negedge clk);
    s_read = 0;
    n = 0;
    cs = int'(rom_chipselect);
    flush = (fl == 0);
    while (!s_readdatavalid && n < 20) begin
      @(negedge clk);
      n++;
      cs += int'(rom_chipselect);
      flush = (fl == n);
    end
    flush = 0;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_data"}, 64'(s_readdata), 64'(d));
    chk({tag, "_cs"}, 64'(cs), 64'(ncs));
    @(negedge clk);
    chk({tag, "_pulse"}, {s_readdatavalid, s_readdata}, {1'b0, d});
  endtask

  initial begin
    int nv, nw, last, gap_bad;
    foreach (mem[i]) mem[i] = {32'(i), ~32'(i)};
    mem[0]   = 64'h1122334455667788;
    mem[1]   = 64'hA1A2A3A4_B1B2B3B4;
    mem[2]   = 64'hC0FFEE00_12345678;
    mem[511] = 64'hDEADBEEF_CAFEF00D;
    repeat (3) @(negedge clk);
    chk("rst_out", {s_waitrequest, s_readdatavalid, s_readdata, rom_address, rom_chipselect, rom_clken},
        {1'b1, 1'b0, 32'h0, 9'h0, 1'b0, 1'b0});
    reset = 0;
    @(negedge clk);
    chk("rel_wr_clken", {s_waitrequest, rom_clken}, 2'b01);
    rd("a0", 10'h000, 32'h55667788, 4, 1, -1);
    rd("a1", 10'h001, 32'h11223344, HIT_LAT, HIT_CS, -1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    rd("a0_flushed", 10'h000, 32'h55667788, 4, 1, -1);
    rd("top", 10'h3FF, 32'hDEADBEEF, 4, 1, -1);
    rd("top_lo", 10'h3FE, 32'hCAFEF00D, HIT_LAT, HIT_CS, -1);
    rd("fl_inflight", 10'h002, 32'hB1B2B3B4, 4, 1, 2);
    rd("fl_same_fill", 10'h002, 32'hB1B2B3B4, 4, 1, -1);
    // continuous reads of one address; flush held keeps every read on the miss path
    flush = 1;
    s_address = 10'h003;
    s_read = 1;
    nv = 0; nw = 0; last = 0; gap_bad = 0;
    for (int i = 0; i <= 25; i++) begin
      if (!s_waitrequest) nw++;
      if (s_readdatavalid) begin
        if (nv > 0 && i - last != 5) gap_bad++;
        if (nv == 0 && i != 5) gap_bad++;
        last = i;
        nv++;
      end
      if (i == 25) begin s_read = 0; flush = 0; end
      @(negedge clk);
    end
    chk("b2b_pulses", 64'(nv), 64'd5);
    chk("b2b_accepts", 64'(nw), 64'd6);
    chk("b2b_gaps", 64'(gap_bad), 64'd0);
    chk("b2b_data", 64'(s_readdata), 64'hA1A2A3A4);
    while (s_waitrequest) @(negedge clk);
    s_address = 10'h004;
    s_read = 1;
    @(negedge clk);
    s_read = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("midrst_out", {s_waitrequest, s_readdatavalid, s_readdata, rom_address, rom_chipselect, rom_clken},
        {1'b1, 1'b0, 32'h0, 9'h0, 1'b0, 1'b0});
    nv = 0;
    repeat (3) begin @(negedge clk); nv += int'(s_readdatavalid); end
    reset = 0;
    repeat (4) begin @(negedge clk); nv += int'(s_readdatavalid); end
    chk("midrst_novalid", 64'(nv), 64'd0);
    rd("after_rst", 10'h004, 32'h12345678, 4, 1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
